// File: rtl/seq11011_pkg.sv
// Shared types and constants for the 11011 serial pattern transmitter.
package seq11011_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } ref_state_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ctrl_state_e;

  localparam logic [4:0] PATTERN     = 5'b11011;
  localparam int         PATTERN_LEN = 5;

  // Non-overlapping Moore transition table: after a detection in S5 the
  // search restarts using only the incoming bit.
  function automatic ref_state_e ref_next(input ref_state_e s, input logic b);
    ref_state_e n;
    n = S0;
    case (s)
      S0:      n = b ? S1 : S0;
      S1:      n = b ? S2 : S0;
      S2:      n = b ? S2 : S3;
      S3:      n = b ? S4 : S0;
      S4:      n = b ? S5 : S0;
      S5:      n = b ? S1 : S0;
      default: n = S0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seq11011_ref_fsm.sv
// Moore, non-overlapping 11011 reference detector; advances only on valid bits.
module seq11011_ref_fsm
  import seq11011_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  input  logic bit_valid,
  output logic det
);

  ref_state_e state_reg;
  ref_state_e state_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S0;
    end else begin
      state_reg <= state_next;
    end
  end

  // State is held across invalid cycles so the stream is treated as contiguous.
  always_comb begin
    state_next = state_reg;
    if (bit_valid) begin
      state_next = ref_next(state_reg, bit_in);
    end
  end

  assign det = (state_reg == S5);

endmodule

// File: rtl/seq11011_tx.sv
// Parallel-load, MSB-first serial transmitter for the 11011 detector family.
// Define SEQ11011_TX_EXPCNT_EN to build the reference FSM and the exp_cnt counter.
module seq11011_tx
  import seq11011_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             done,
  output logic [CNT_W-1:0] exp_cnt
);

  localparam int BC_W = $clog2(WIDTH + 1);

  ctrl_state_e      state_reg,  state_next;
  logic [WIDTH-1:0] shreg_reg,  shreg_next;
  logic [BC_W-1:0]  bitcnt_reg, bitcnt_next;
  logic             out_reg,    out_next;
  logic             valid_reg,  valid_next;
  logic             done_reg,   done_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      shreg_reg  <= '0;
      bitcnt_reg <= '0;
      out_reg    <= 1'b0;
      valid_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      shreg_reg  <= shreg_next;
      bitcnt_reg <= bitcnt_next;
      out_reg    <= out_next;
      valid_reg  <= valid_next;
      done_reg   <= done_next;
    end
  end

  // bitcnt counts bits already placed on out; the word ends once it reaches WIDTH.
  always_comb begin
    state_next  = state_reg;
    shreg_next  = shreg_reg;
    bitcnt_next = bitcnt_reg;
    out_next    = out_reg;
    valid_next  = valid_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load_valid) begin
          state_next  = SHIFT;
          out_next    = data_in[WIDTH-1];
          valid_next  = 1'b1;
          shreg_next  = data_in << 1;
          bitcnt_next = BC_W'(1);
        end
      end
      SHIFT: begin
        if (bitcnt_reg == BC_W'(WIDTH)) begin
          state_next = IDLE;
          out_next   = 1'b0;
          valid_next = 1'b0;
          done_next  = 1'b1;
        end else begin
          out_next    = shreg_reg[WIDTH-1];
          shreg_next  = shreg_reg << 1;
          bitcnt_next = bitcnt_reg + BC_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        out_next   = 1'b0;
        valid_next = 1'b0;
      end
    endcase
  end

  assign load_ready = (state_reg == IDLE);
  assign out        = out_reg;
  assign out_valid  = valid_reg;
  assign done       = done_reg;

`ifdef SEQ11011_TX_EXPCNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             det;
  logic             det_d_reg;
  logic             det_rise;
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt_reg;

  seq11011_ref_fsm u_ref_fsm (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (out_reg),
    .bit_valid (valid_reg),
    .det       (det)
  );

  // S5 cannot be re-entered without leaving it first, so a rising det marks
  // each entry exactly once even when S5 is held through an idle gap.
  assign det_rise = det & ~det_d_reg;
  assign cnt_inc  = det_rise && (cnt_reg != CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      det_d_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      det_d_reg <= det;
      if (cnt_inc) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  // Fold the pending increment in so the count is visible right after the edge
  // that consumed the final pattern bit.
  assign exp_cnt = cnt_inc ? (cnt_reg + CNT_W'(1)) : cnt_reg;
`else
  assign exp_cnt = '0;
`endif

endmodule

// File: tb/tb_seq11011_tx.sv
// Scoreboard bench for seq11011_tx: driver pushes expected bits/counts, monitor pops and compares.
module tb_seq11011_tx;

  localparam int WIDTH   = 16;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SEQ11011_TX_EXPCNT_EN
  localparam bit EXP_EN = 1'b1;
`else
  localparam bit EXP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] data_in = '0;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic             out;
  logic             out_valid;
  logic             done;
  logic [CNT_W-1:0] exp_cnt;

  seq11011_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .out        (out),
    .out_valid  (out_valid),
    .done       (done),
    .exp_cnt    (exp_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic b;
    int   cnt;
  } bit_exp_t;

  bit_exp_t bit_q[$];
  int       done_q[$];
  logic     win[$];
  int       m_cnt   = 0;
  int       run_len = 0;
  int       n_checks = 0;
  int       n_pass   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  function automatic int exp_of(input int n);
    return EXP_EN ? n : 0;
  endfunction

  // Reference: count leftmost non-overlapping 11011 matches over the valid-bit stream.
  task automatic push_word(input logic [WIDTH-1:0] w);
    bit_exp_t e;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      e.b   = w[i];
      e.cnt = exp_of(m_cnt);
      bit_q.push_back(e);
      win.push_back(w[i]);
      if (win.size() > 5) void'(win.pop_front());
      if (win.size() == 5 && {win[0], win[1], win[2], win[3], win[4]} == 5'b11011) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        win.delete();
      end
    end
    done_q.push_back(exp_of(m_cnt));
    $display("word %h accepted, expected count after word %0d", w, exp_of(m_cnt));
  endtask

  task automatic send(input logic [WIDTH-1:0] w, output int waited);
    waited     = 0;
    data_in    = w;
    load_valid = 1'b1;
    while (!load_ready && waited < 3 * WIDTH) begin
      @(negedge clk);
      waited++;
    end
    if (!load_ready) begin
      check("load_ready_timeout", load_ready, 1);
      load_valid = 1'b0;
    end else begin
      push_word(w);
      @(negedge clk);
      load_valid = 1'b0;
      check("first_bit_latency", out_valid, 1);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 3 * WIDTH) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    bit_q.delete();
    done_q.delete();
    win.delete();
    m_cnt   = 0;
    run_len = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor
  bit_exp_t mon_e;
  int       mon_d;
  always @(negedge clk) begin
    if (out_valid) begin
      run_len++;
      if (bit_q.size() == 0) begin
        check("pending_bit", 0, 1);
      end else begin
        mon_e = bit_q.pop_front();
        check("out_bit", out, mon_e.b);
        check("exp_cnt_bit", exp_cnt, mon_e.cnt);
      end
    end else begin
      check("out_idle_zero", out, 0);
      if (run_len != 0) begin
        check("run_len", run_len, WIDTH);
        check("done_after_last", done, 1);
        run_len = 0;
      end
    end
    if (done) begin
      check("done_out_valid", out_valid, 0);
      if (done_q.size() == 0) begin
        check("done_expected", 0, 1);
      end else begin
        mon_d = done_q.pop_front();
        check("exp_cnt_done", exp_cnt, mon_d);
      end
    end
  end

  initial begin
    int waited;
    logic [WIDTH-1:0] w;
    logic [3:0] nib;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_out", out, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_done", done, 0);
      check("rst_load_ready", load_ready, 1);
      check("rst_exp_cnt", exp_cnt, 0);
      @(negedge clk);
    end

    send(16'hDB6C, waited);
    wait_done();
    check("exp_cnt_db6c", exp_cnt, exp_of(2));

    send(16'hFFFF, waited);
    wait_done();
    check("exp_cnt_ffff", exp_cnt, exp_of(2));

    send(16'h0003, waited);
    wait_done();
    send(16'h6000, waited);
    check("b2b_accept_in_done", waited, 0);
    wait_done();
    check("exp_cnt_boundary", exp_cnt, exp_of(3));

    send(16'h0F0F, waited);
    send(16'hAAAA, waited);
    check("hold_wait_cycles", waited, WIDTH);
    wait_done();

    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        w = WIDTH'($urandom);
      end else begin
        for (int j = 0; j < WIDTH / 4; j++) begin
          case ($urandom_range(0, 3))
            0: nib = 4'hD;
            1: nib = 4'hB;
            2: nib = 4'h6;
            default: nib = 4'h3;
          endcase
          w = {w[WIDTH-5:0], nib};
        end
      end
      send(w, waited);
    end
    wait_done();

    send(16'hDB6C, waited);
    repeat (6) @(negedge clk);
    do_reset();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out", out, 0);
    check("midrst_done", done, 0);
    check("midrst_exp_cnt", exp_cnt, 0);
    check("midrst_load_ready", load_ready, 1);
    @(negedge clk);
    check("midrst_no_done", done, 0);

    data_in    = 16'h1234;
    load_valid = 1'b1;
    do_reset();
    load_valid = 1'b0;
    check("rst_wins_load_ready", load_ready, 1);
    check("rst_wins_out_valid", out_valid, 0);
    @(negedge clk);

    send(16'hDB6C, waited);
    wait_done();
    check("after_rst_exp_cnt", exp_cnt, exp_of(2));

    for (int k = 0; k < 140; k++) begin
      send(16'hDB6C, waited);
    end
    wait_done();
    check("exp_cnt_saturated", exp_cnt, exp_of(CNT_MAX));

    repeat (3) @(negedge clk);
    check("bits_drained", bit_q.size(), 0);
    check("dones_drained", done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
